// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory access controller: op codes, FSM
// state encoding, address-exception codes, memory word-address width and a few
// small op-classification helpers.
// -----------------------------------------------------------------------------
package dm_pkg;

   localparam int DM_ADDR_W = 13;

   // Operation codes; anything not listed here is treated as a NOP.
   localparam logic [3:0] OP_LW  = 4'd0;
   localparam logic [3:0] OP_LH  = 4'd1;
   localparam logic [3:0] OP_LHU = 4'd2;
   localparam logic [3:0] OP_LB  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_SW  = 4'd8;
   localparam logic [3:0] OP_SH  = 4'd9;
   localparam logic [3:0] OP_SB  = 4'd10;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } dm_state_e;

   function automatic logic is_load(input logic [3:0] op);
      return (op <= OP_LBU);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   endfunction

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [1:0] align_mask(input logic [3:0] op);
      case (op)
         OP_LW, OP_SW:          return 2'b11;
         OP_LH, OP_LHU, OP_SH:  return 2'b01;
         default:               return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// -----------------------------------------------------------------------------
// dm_lane_align
// Purely combinational byte-lane steering for the data memory.
//   op      : operation code
//   addr_lo : byte offset within the word
//   wdata   : right-aligned store data
//   rd      : memory read word
//   be      : byte enables (stores only, zero otherwise)
//   wd      : lane-replicated write data (stores only, zero otherwise)
//   ld_data : extracted, sign/zero-extended load data (zero for non-loads)
// Word ops ignore addr_lo and halfword ops ignore addr_lo[0], so misaligned
// low bits simply round down when no exception check is present.
// -----------------------------------------------------------------------------
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rd,
   output logic [3:0]  be,
   output logic [31:0] wd,
   output logic [31:0] ld_data
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign rd_byte = rd[{addr_lo, 3'b000} +: 8];
   assign rd_half = rd[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      be = 4'b0000;
      wd = 32'h0;
      case (op)
         OP_SW: begin
            be = 4'b1111;
            wd = wdata;
         end
         OP_SH: begin
            be = addr_lo[1] ? 4'b1100 : 4'b0011;
            wd = {2{wdata[15:0]}};
         end
         OP_SB: begin
            be = 4'b0001 << addr_lo;
            wd = {4{wdata[7:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_data = 32'h0;
      case (op)
         OP_LW:   ld_data = rd;
         OP_LH:   ld_data = {{16{rd_half[15]}}, rd_half};
         OP_LHU:  ld_data = {16'h0, rd_half};
         OP_LB:   ld_data = {{24{rd_byte[7]}}, rd_byte};
         OP_LBU:  ld_data = {24'h0, rd_byte};
         default: ;
      endcase
   end

endmodule

// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
// Load/store initiator for the 8 KB byte-enabled data memory. One request at a
// time: IDLE (accept) -> ACCESS (one memory cycle) -> RESP (held until taken).
//   Clk, Rst_n                 : clock, async active-low reset
//   Req_valid/ready/op/addr/wdata : request channel from the MEM stage
//   Rsp_valid/ready/rdata/exc/exccode : held response channel
//   A, BE, WD, We, RD          : data memory port (RD is combinational)
// Optional feature: define DM_ACCESS_CTRL_EXC_EN to raise address exceptions
// for misaligned or out-of-window accesses; otherwise Rsp_exc/code stay 0.
// -----------------------------------------------------------------------------
module dm_access_ctrl
   import dm_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Req_valid,
   output logic                 Req_ready,
   input  logic [3:0]           Req_op,
   input  logic [31:0]          Req_addr,
   input  logic [31:0]          Req_wdata,
   output logic                 Rsp_valid,
   input  logic                 Rsp_ready,
   output logic [31:0]          Rsp_rdata,
   output logic                 Rsp_exc,
   output logic [4:0]           Rsp_exccode,
   output logic [DM_ADDR_W-1:0] A,
   output logic [3:0]           BE,
   output logic [31:0]          WD,
   output logic                 We,
   input  logic [31:0]          RD
);

   dm_state_e   state, state_nxt;
   logic [3:0]  op_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic        exc_q;
   logic [4:0]  exccode_q;
   logic [3:0]  be_raw;
   logic [31:0] wd_raw, ld_data;
   logic        acc_exc;

   dm_lane_align u_lane_align (
      .op      (op_q),
      .addr_lo (addr_q[1:0]),
      .wdata   (wdata_q),
      .rd      (RD),
      .be      (be_raw),
      .wd      (wd_raw),
      .ld_data (ld_data)
   );

`ifdef DM_ACCESS_CTRL_EXC_EN
   logic misaligned, out_of_win;
   assign misaligned = |(addr_q[1:0] & align_mask(op_q));
   assign out_of_win = (addr_q[31:13] != BASE_ADDR[31:13]);
   // NOPs never touch memory, so they never fault.
   assign acc_exc    = (is_load(op_q) || is_store(op_q)) && (misaligned || out_of_win);
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_q[31:DM_ADDR_W+2], BASE_ADDR};
   assign acc_exc = 1'b0;
`endif

   // State register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (Req_valid) state_nxt = ST_ACCESS;
         ST_ACCESS: state_nxt = ST_RESP;
         ST_RESP:   if (Rsp_ready) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: strobes decode from state so reset kills We asynchronously.
   always_comb begin
      Req_ready = (state == ST_IDLE);
      Rsp_valid = (state == ST_RESP);
      We        = (state == ST_ACCESS) && is_store(op_q) && !acc_exc;
      BE        = ((state == ST_ACCESS) && !acc_exc) ? be_raw : 4'b0000;
   end

   // Request latch and response capture
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         op_q      <= OP_LW;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         exc_q     <= 1'b0;
         exccode_q <= '0;
      end else begin
         if (state == ST_IDLE && Req_valid) begin
            op_q    <= Req_op;
            addr_q  <= Req_addr;
            wdata_q <= Req_wdata;
         end
         if (state == ST_ACCESS) begin
            rdata_q   <= (is_load(op_q) && !acc_exc) ? ld_data : 32'h0;
            exc_q     <= acc_exc;
            exccode_q <= !acc_exc          ? 5'd0     :
                         is_store(op_q)    ? EXC_ADES : EXC_ADEL;
         end
      end
   end

   // A and WD derive only from latched request state, so they hold between accesses.
   assign A           = addr_q[DM_ADDR_W+1:2];
   assign WD          = wd_raw;
   assign Rsp_rdata   = rdata_q;
   assign Rsp_exc     = exc_q;
   assign Rsp_exccode = exccode_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_access_ctrl
// Directed plus random load/store traffic against a byte-array reference of
// the 8 KB data memory. The memory attached to the DUT is a 2048-word array
// indexed by the low 11 bits of A.
// -----------------------------------------------------------------------------
module tb_dm_access_ctrl;
   import dm_pkg::*;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Req_valid, Req_ready;
   logic [3:0]  Req_op;
   logic [31:0] Req_addr, Req_wdata;
   logic        Rsp_valid, Rsp_ready;
   logic [31:0] Rsp_rdata;
   logic        Rsp_exc;
   logic [4:0]  Rsp_exccode;
   logic [12:0] A;
   logic [3:0]  BE;
   logic [31:0] WD;
   logic        We;
   logic [31:0] RD;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   dm_access_ctrl dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_op(Req_op),
      .Req_addr(Req_addr), .Req_wdata(Req_wdata),
      .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready), .Rsp_rdata(Rsp_rdata),
      .Rsp_exc(Rsp_exc), .Rsp_exccode(Rsp_exccode),
      .A(A), .BE(BE), .WD(WD), .We(We), .RD(RD)
   );

   // Memory attached to the DUT
   logic [31:0] mem [0:2047];
   assign RD = mem[A[10:0]];
   always @(posedge Clk)
      if (We)
         for (int b = 0; b < 4; b++)
            if (BE[b]) mem[A[10:0]][8*b +: 8] <= WD[8*b +: 8];

   // Reference: flat byte array of the 8 KB window
   logic [7:0] rmem [0:8191];

   // Model outputs
   logic [31:0] m_rd, m_wd;
   logic        m_exc, m_we;
   logic [4:0]  m_code;
   logic [3:0]  m_be;

   // Observations from the last run_req
   logic [31:0] obs_rd, obs_wd;
   logic [12:0] obs_a;
   logic [3:0]  obs_be;
   logic        obs_we, obs_exc;
   logic [4:0]  obs_code;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int op_size(input logic [3:0] op);
      if (op == OP_LW || op == OP_SW) return 4;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
      if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
      return 0;
   endfunction

   // Expected behaviour of one request given the current reference memory.
   task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdat);
      int sz, base;
      bit ld, st;
      sz = op_size(op);
      ld = (op <= 4'd4);
      st = (sz > 0) && !ld;
      m_exc = 1'b0;
`ifdef DM_ACCESS_CTRL_EXC_EN
      if (sz > 0 && ((int'(addr[1:0]) % sz) != 0 || addr[31:13] != 19'd0)) m_exc = 1'b1;
`endif
      m_code = !m_exc ? 5'd0 : (st ? 5'd5 : 5'd4);
      base = (sz > 0) ? int'(addr[12:0]) - (int'(addr[12:0]) % sz) : 0;
      m_rd = 32'h0; m_be = 4'h0; m_wd = 32'h0;
      m_we = st && !m_exc;
      if (ld && !m_exc) begin
         for (int i = 0; i < sz; i++) m_rd[8*i +: 8] = rmem[base + i];
         if ((op == OP_LB || op == OP_LH) && m_rd[8*sz-1])
            for (int i = 8*sz; i < 32; i++) m_rd[i] = 1'b1;
      end
      if (m_we) begin
         for (int i = 0; i < sz; i++) m_be[(base + i) % 4] = 1'b1;
         for (int i = 0; i < 4; i++) m_wd[8*i +: 8] = wdat[8*(i % sz) +: 8];
      end
   endtask

   task automatic commit(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdat);
      int sz, base;
      sz = op_size(op);
      base = int'(addr[12:0]) - (int'(addr[12:0]) % sz);
      for (int i = 0; i < sz; i++) rmem[base + i] = wdat[8*i +: 8];
   endtask

   task automatic run_req(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdat, input int hold);
      int n;
      logic st_commit;
      model(op, addr, wdat);
      st_commit = m_we;
      n = 0;
      while (Req_ready !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
      chk("req_ready_idle", {31'h0, Req_ready}, 32'd1);
      Req_valid = 1'b1; Req_op = op; Req_addr = addr; Req_wdata = wdat;
      @(posedge Clk); #1 Req_valid = 1'b0;
      @(negedge Clk);
      obs_we = We; obs_be = BE; obs_a = A; obs_wd = WD;
      chk("acc_ready", {31'h0, Req_ready}, 32'd0);
      chk("acc_rsp_valid", {31'h0, Rsp_valid}, 32'd0);
      chk("acc_we", {31'h0, We}, {31'h0, m_we});
      chk("acc_be", {28'h0, BE}, {28'h0, m_be});
      chk("acc_a", {19'h0, A}, {19'h0, addr[14:2]});
      if (m_we) chk("acc_wd", WD, m_wd);
      @(negedge Clk);
      obs_rd = Rsp_rdata; obs_exc = Rsp_exc; obs_code = Rsp_exccode;
      chk("rsp_valid", {31'h0, Rsp_valid}, 32'd1);
      chk("rsp_rdata", Rsp_rdata, m_rd);
      chk("rsp_exc", {31'h0, Rsp_exc}, {31'h0, m_exc});
      chk("rsp_code", {27'h0, Rsp_exccode}, {27'h0, m_code});
      for (int i = 0; i < hold; i++) begin
         @(negedge Clk);
         chk("hold_valid", {31'h0, Rsp_valid}, 32'd1);
         chk("hold_rdata", Rsp_rdata, m_rd);
      end
      Rsp_ready = 1'b1;
      @(posedge Clk); #1 Rsp_ready = 1'b0;
      if (st_commit) commit(op, addr, wdat);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_req_ready"}, {31'h0, Req_ready}, 32'd1);
      chk({pfx, "_rsp_valid"}, {31'h0, Rsp_valid}, 32'd0);
      chk({pfx, "_rsp_exc"}, {31'h0, Rsp_exc}, 32'd0);
      chk({pfx, "_we"}, {31'h0, We}, 32'd0);
      chk({pfx, "_rdata"}, Rsp_rdata, 32'd0);
      chk({pfx, "_code"}, {27'h0, Rsp_exccode}, 32'd0);
      chk({pfx, "_a"}, {19'h0, A}, 32'd0);
      chk({pfx, "_be"}, {28'h0, BE}, 32'd0);
      chk({pfx, "_wd"}, WD, 32'd0);
   endtask

   initial begin
      logic [3:0]  rops [0:9];
      logic [31:0] ra, e1, e2, wexp;
      rops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, 4'd5, 4'd13};
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
      for (int i = 0; i < 8192; i++) rmem[i] = 8'h0;
      Rst_n = 1'b0; Req_valid = 1'b0; Req_op = 4'h0; Req_addr = 32'h0;
      Req_wdata = 32'h0; Rsp_ready = 1'b0;
      repeat (2) @(negedge Clk);
      chk_reset_vals("in_reset");
      Rst_n = 1'b1;
      @(negedge Clk);
      chk_reset_vals("after_reset");

      // Word store then load
      run_req(OP_SW, 32'h10, 32'hDEADBEEF, 0);
      chk("sw_be", {28'h0, obs_be}, 32'hF);
      chk("sw_a", {19'h0, obs_a}, 32'd4);
      chk("sw_we", {31'h0, obs_we}, 32'd1);
      run_req(OP_LW, 32'h10, 32'h0, 0);
      chk("lw_data", obs_rd, 32'hDEADBEEF);

      // Byte store, signed and unsigned byte loads
      run_req(OP_SB, 32'h13, 32'h80, 1);
      chk("sb_be", {28'h0, obs_be}, 32'h8);
      chk("sb_wd", obs_wd, 32'h80808080);
      run_req(OP_LB, 32'h13, 32'h0, 0);
      chk("lb_data", obs_rd, 32'hFFFFFF80);
      run_req(OP_LBU, 32'h13, 32'h0, 0);
      chk("lbu_data", obs_rd, 32'h00000080);

      // Halfword store / signed halfword load
      run_req(OP_SH, 32'h22, 32'h1234ABCD, 0);
      chk("sh_be", {28'h0, obs_be}, 32'hC);
      chk("sh_wd", obs_wd, 32'hABCDABCD);
      run_req(OP_LH, 32'h22, 32'h0, 2);
      chk("lh_data", obs_rd, 32'hFFFFABCD);

      // Response back-pressure with a second request waiting
      model(OP_LBU, 32'h13, 32'h0); e1 = m_rd;
      model(OP_LW, 32'h10, 32'h0);  e2 = m_rd;
      @(negedge Clk);
      Req_valid = 1'b1; Req_op = OP_LBU; Req_addr = 32'h13; Req_wdata = 32'h0;
      @(posedge Clk); #1 Req_op = OP_LW; Req_addr = 32'h10;
      @(negedge Clk);
      chk("stall_acc_ready", {31'h0, Req_ready}, 32'd0);
      @(negedge Clk);
      chk("stall_rsp_valid", {31'h0, Rsp_valid}, 32'd1);
      chk("stall_rdata", Rsp_rdata, e1);
      repeat (5) begin
         @(negedge Clk);
         chk("stall_hold_valid", {31'h0, Rsp_valid}, 32'd1);
         chk("stall_hold_rdata", Rsp_rdata, e1);
         chk("stall_hold_ready", {31'h0, Req_ready}, 32'd0);
      end
      Rsp_ready = 1'b1;
      @(posedge Clk); #1 Rsp_ready = 1'b0;
      @(negedge Clk);
      chk("stall_idle_ready", {31'h0, Req_ready}, 32'd1);
      chk("stall_idle_valid", {31'h0, Rsp_valid}, 32'd0);
      @(posedge Clk); #1 Req_valid = 1'b0;
      @(negedge Clk);
      chk("stall2_acc_ready", {31'h0, Req_ready}, 32'd0);
      chk("stall2_acc_a", {19'h0, A}, 32'd4);
      @(negedge Clk);
      chk("stall2_rsp_valid", {31'h0, Rsp_valid}, 32'd1);
      chk("stall2_rdata", Rsp_rdata, e2);
      Rsp_ready = 1'b1;
      @(posedge Clk); #1 Rsp_ready = 1'b0;

      // Out-of-window and misaligned accesses
      run_req(OP_SW, 32'h0, 32'h11223344, 0);
      run_req(OP_LW, 32'h2000, 32'h0, 0);
`ifdef DM_ACCESS_CTRL_EXC_EN
      chk("oow_exc", {31'h0, obs_exc}, 32'd1);
      chk("oow_code", {27'h0, obs_code}, 32'd4);
      chk("oow_rdata", obs_rd, 32'h0);
`else
      chk("wrap_exc", {31'h0, obs_exc}, 32'd0);
      chk("wrap_rdata", obs_rd, 32'h11223344);
`endif
      run_req(OP_SW, 32'h11, 32'h55667788, 0);
`ifdef DM_ACCESS_CTRL_EXC_EN
      chk("mis_exc", {31'h0, obs_exc}, 32'd1);
      chk("mis_code", {27'h0, obs_code}, 32'd5);
      chk("mis_we", {31'h0, obs_we}, 32'd0);
`else
      chk("mis_we", {31'h0, obs_we}, 32'd1);
      chk("mis_a", {19'h0, obs_a}, 32'd4);
`endif

      // Random traffic
      for (int t = 0; t < 60; t++) begin
         ra = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) ra[31:13] = 19'($urandom());
         run_req(rops[$urandom_range(0, 9)], ra, $urandom(), int'($urandom_range(0, 2)));
      end

      // Reset during a store's memory cycle
      @(negedge Clk);
      Req_valid = 1'b1; Req_op = OP_SW; Req_addr = 32'h40; Req_wdata = 32'hCAFEF00D;
      @(posedge Clk); #1 Req_valid = 1'b0;
      @(negedge Clk);
      chk("rst_we_before", {31'h0, We}, 32'd1);
      #2 Rst_n = 1'b0;
      #1 chk("rst_we_async", {31'h0, We}, 32'd0);
      @(negedge Clk); Rst_n = 1'b1;
      @(negedge Clk);
      chk_reset_vals("post_rst");

      // Memory contents against the reference
      for (int w = 0; w < 32; w++) begin
         wexp = {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
         chk("mem_word", mem[w], wexp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
